// File: rtl/ofb_pkg.sv
// Shared constants and types for the OFB stream encryptor and its AES core.
package ofb_pkg;
    localparam int BLK_W          = 128;
    localparam int AES_KEY_W      = 128;
    localparam int MAX_BLOCKS_DEF = 65536;
    localparam int CNT_W_DEF      = 17;

    // Bit numbering follows the existing OFB datapath: [128:1], bit 128 is the MSB.
    typedef logic [BLK_W:1]     blk_t;
    typedef logic [AES_KEY_W:1] key_t;

    // Encryptor FSM encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GEN     = 2'd1;
    localparam logic [1:0] ST_WAIT_IN = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;
endpackage

// File: rtl/ofb_stream_enc_if.sv
// Plaintext-in / ciphertext-out valid/ready streams of the OFB encryptor.
interface ofb_stream_enc_if;
    import ofb_pkg::*;

    logic in_valid;
    logic in_ready;
    blk_t in_data;
    logic in_last;
    logic out_valid;
    logic out_ready;
    blk_t out_data;
    logic out_last;

    // Producer of plaintext and consumer of ciphertext.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // The encryptor itself.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/aes128_core.sv
// Combinational AES-128 encryption with on-the-fly key expansion.
module aes128_core
    import ofb_pkg::*;
(
    input  blk_t pt,
    input  key_t key,
    output blk_t ct
);
    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = SBOX[x[8*i +: 8]];
        return y;
    endfunction

    // State byte (row r, column c) sits at index r + 4c, counted from the MSB.
    function automatic logic [127:0] shift_rows(input logic [127:0] x);
        logic [127:0] y;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
        return y;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            y[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            y[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            y[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            y[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return y;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [127:0] st;
    logic [127:0] rk;

    // Ten rounds unrolled; the round key is derived alongside each round.
    always_comb begin
        rk = key;
        st = pt ^ key;
        for (int r = 1; r <= 10; r++) begin
            rk = key_next(rk, RCON[r]);
            if (r < 10) st = mix_columns(shift_rows(sub_bytes(st))) ^ rk;
            else        st = shift_rows(sub_bytes(st)) ^ rk;
        end
        ct = st;
    end
endmodule

// File: rtl/ofb_stream_enc.sv
// AES-128 OFB stream encryptor: one keystream block per plaintext block,
// each AES output chained back as the next feedback value.
module ofb_stream_enc
    import ofb_pkg::*;
#(
    parameter int MAX_BLOCKS = MAX_BLOCKS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  key_t             key,
    input  blk_t             iv,
    ofb_stream_enc_if.slave  strm,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] blk_count
);
    logic [1:0]       state;
    key_t             key_r;
    blk_t             fb;
    blk_t             ks;
    blk_t             out_data_r;
    logic             out_last_r;
    blk_t             aes_out;
    logic [CNT_W-1:0] cnt_inc;
    logic             max_hit;

    aes128_core u_aes (
        .pt  (fb),
        .key (key_r),
        .ct  (aes_out)
    );

    // The block about to be accepted is number blk_count+1; reaching the cap forces it last.
    assign cnt_inc = blk_count + CNT_W'(1);
    assign max_hit = (cnt_inc == CNT_W'(MAX_BLOCKS));

    assign strm.in_ready  = (state == ST_WAIT_IN);
    assign strm.out_valid = (state == ST_SEND);
    assign strm.out_data  = out_data_r;
    assign strm.out_last  = out_last_r;
    assign busy           = (state != ST_IDLE);

    // Message FSM and all datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            key_r      <= '0;
            fb         <= '0;
            ks         <= '0;
            out_data_r <= '0;
            out_last_r <= 1'b0;
            blk_count  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_r     <= key;
                        fb        <= iv;
                        blk_count <= '0;
                        state     <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    ks    <= aes_out;
                    fb    <= aes_out;
                    state <= ST_WAIT_IN;
                end
                ST_WAIT_IN: begin
                    if (strm.in_valid) begin
                        out_data_r <= strm.in_data ^ ks;
                        out_last_r <= strm.in_last | max_hit;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (strm.out_ready) begin
                        blk_count <= cnt_inc;
                        if (out_last_r) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_GEN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ofb_stream_enc.sv
// Directed bench for ofb_stream_enc using the SP800-38A OFB vectors.
module tb_ofb_stream_enc;
    localparam logic [128:1] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [128:1] IV   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [128:1] IV_X = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [128:1] PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [128:1] PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [128:1] PT3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [128:1] PT4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [128:1] CT1  = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [128:1] CT2  = 128'h7789508d16918f03f53c52dac54ed825;
    localparam logic [128:1] CT3  = 128'h9740051e9c5fecf64344f7a82260edcc;
    localparam logic [128:1] CT4  = 128'h304c6528f659c77866a510d9c1d6ae5e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, sel = 1'b0, start = 1'b0;
    logic [128:1]  key = '0, iv = '0, in_data = '0;
    logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;

    logic          busy1, done1, busy2, done2;
    logic [16:0]   cnt1, cnt2;

    ofb_stream_enc_if if1 ();
    ofb_stream_enc_if if2 ();

    // sel routes stimulus to the default DUT (0) or the MAX_BLOCKS=4 DUT (1).
    assign if1.in_valid  = in_valid & ~sel;
    assign if1.in_data   = in_data;
    assign if1.in_last   = in_last;
    assign if1.out_ready = out_ready & ~sel;
    assign if2.in_valid  = in_valid & sel;
    assign if2.in_data   = in_data;
    assign if2.in_last   = in_last;
    assign if2.out_ready = out_ready & sel;

    ofb_stream_enc u_dut (
        .clk(clk), .rst(rst), .start(start & ~sel), .key(key), .iv(iv),
        .strm(if1.slave), .busy(busy1), .done(done1), .blk_count(cnt1)
    );

    ofb_stream_enc #(.MAX_BLOCKS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start & sel), .key(key), .iv(iv),
        .strm(if2.slave), .busy(busy2), .done(done2), .blk_count(cnt2)
    );

    logic          in_ready_o, out_valid_o, out_last_o, busy_o, done_o;
    logic [128:1]  out_data_o;
    logic [16:0]   cnt_o;
    assign in_ready_o  = sel ? if2.in_ready  : if1.in_ready;
    assign out_valid_o = sel ? if2.out_valid : if1.out_valid;
    assign out_data_o  = sel ? if2.out_data  : if1.out_data;
    assign out_last_o  = sel ? if2.out_last  : if1.out_last;
    assign busy_o      = sel ? busy2 : busy1;
    assign done_o      = sel ? done2 : done1;
    assign cnt_o       = sel ? cnt2  : cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [128:1] k, input logic [128:1] v);
        key = k; iv = v; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Push one block and pop its ciphertext; ok=0 if either handshake times out.
    task automatic send_block(input logic [128:1] pt, input logic lst,
                              output logic [128:1] ct, output logic olast, output logic ok);
        int i;
        ok = 1'b1; ct = '0; olast = 1'b0;
        in_data = pt; in_last = lst; in_valid = 1'b1;
        i = 0;
        while (!in_ready_o && i < 20) begin tick(); i++; end
        if (!in_ready_o) begin ok = 1'b0; in_valid = 1'b0; return; end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        i = 0;
        while (!out_valid_o && i < 20) begin tick(); i++; end
        if (!out_valid_o) begin ok = 1'b0; return; end
        ct = out_data_o; olast = out_last_o;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        key = KEY; iv = IV; start = 1'b1; rst = 1'b1;
        tick(); tick();
        start = 1'b0;
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
        n_checks++; if (out_data_o !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data_o); end
        n_checks++; if (out_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy (rst over start) got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
        n_checks++; if (cnt_o !== 17'd0) begin n_fail++; $display("FAIL reset_blk_count got %0d want 0", cnt_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sp800_block1();
        logic [128:1] ct; logic ol, ok;
        do_start(KEY, IV);
        n_checks++; if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL lat_gen in_ready=%b busy=%b want 0/1", in_ready_o, busy_o); end
        tick();
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready_n2 got %b want 1", in_ready_o); end
        send_block(PT1, 1'b1, ct, ol, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sp800_handshake timed out got %b want 1", ok); end
        n_checks++; if (ct !== CT1) begin n_fail++; $display("FAIL sp800_ct got %h want %h", ct, CT1); end
        n_checks++; if (ol !== 1'b1) begin n_fail++; $display("FAIL sp800_last got %b want 1", ol); end
        n_checks++; if (cnt_o !== 17'd1) begin n_fail++; $display("FAIL sp800_blk_count got %0d want 1", cnt_o); end
        n_checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL sp800_done done=%b busy=%b want 1/0", done_o, busy_o); end
        tick();
    endtask

    task automatic test_four_block();
        logic [128:1] pts [4] = '{PT1, PT2, PT3, PT4};
        logic [128:1] cts [4] = '{CT1, CT2, CT3, CT4};
        logic [128:1] ct; logic ol, ok;
        int dones = 0;
        do_start(KEY, IV);
        for (int b = 0; b < 4; b++) begin
            send_block(pts[b], (b == 3), ct, ol, ok);
            if (done_o === 1'b1) dones++;
            n_checks++; if (ok !== 1'b1 || ct !== cts[b]) begin n_fail++; $display("FAIL four_ct%0d got %h want %h (ok=%b)", b + 1, ct, cts[b], ok); end
            n_checks++; if (ol !== (b == 3)) begin n_fail++; $display("FAIL four_last%0d got %b want %b", b + 1, ol, (b == 3)); end
        end
        n_checks++; if (cnt_o !== 17'd4) begin n_fail++; $display("FAIL four_blk_count got %0d want 4", cnt_o); end
        tick();
        if (done_o === 1'b1) dones++;
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL four_done_pulses got %0d want 1", dones); end
    endtask

    task automatic test_backpressure();
        logic [128:1] ct; logic ol, ok;
        int i;
        do_start(KEY, IV);
        send_block(PT1, 1'b0, ct, ol, ok);
        n_checks++; if (ct !== CT1) begin n_fail++; $display("FAIL bp_ct1 got %h want %h", ct, CT1); end
        in_data = PT2; in_valid = 1'b1;
        i = 0;
        while (!in_ready_o && i < 20) begin tick(); i++; end
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d got %b want 1", c, out_valid_o); end
            n_checks++; if (out_data_o !== CT2) begin n_fail++; $display("FAIL bp_data c%0d got %h want %h", c, out_data_o, CT2); end
            n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready_o); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (cnt_o !== 17'd2) begin n_fail++; $display("FAIL bp_count2 got %0d want 2", cnt_o); end
        send_block(PT3, 1'b0, ct, ol, ok);
        n_checks++; if (ct !== CT3) begin n_fail++; $display("FAIL bp_ct3 got %h want %h", ct, CT3); end
        send_block(PT4, 1'b1, ct, ol, ok);
        n_checks++; if (ct !== CT4 || ol !== 1'b1) begin n_fail++; $display("FAIL bp_ct4 got %h/%b want %h/1", ct, ol, CT4); end
        n_checks++; if (cnt_o !== 17'd4) begin n_fail++; $display("FAIL bp_blk_count got %0d want 4", cnt_o); end
        tick();
    endtask

    task automatic test_rst_mid();
        logic [128:1] ct; logic ol, ok;
        int i;
        do_start(KEY, IV);
        send_block(PT1, 1'b0, ct, ol, ok);
        in_data = PT2; in_valid = 1'b1;
        i = 0;
        while (!in_ready_o && i < 20) begin tick(); i++; end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_send got %b want 1", out_valid_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ({in_ready_o, out_valid_o, out_last_o, busy_o, done_o} !== 5'b0) begin n_fail++; $display("FAIL rst_flags got %b want 00000", {in_ready_o, out_valid_o, out_last_o, busy_o, done_o}); end
        n_checks++; if (out_data_o !== 128'h0) begin n_fail++; $display("FAIL rst_out_data got %h want 0", out_data_o); end
        n_checks++; if (cnt_o !== 17'd0) begin n_fail++; $display("FAIL rst_blk_count got %0d want 0", cnt_o); end
        do_start(KEY, IV);
        send_block(PT1, 1'b1, ct, ol, ok);
        n_checks++; if (ok !== 1'b1 || ct !== CT1) begin n_fail++; $display("FAIL rst_restart_ct got %h want %h (ok=%b)", ct, CT1, ok); end
        tick();
    endtask

    task automatic test_start_busy();
        logic [128:1] ct; logic ol, ok;
        do_start(KEY, IV);
        do_start(KEY, IV_X);
        do_start(KEY, IV_X);
        send_block(PT1, 1'b0, ct, ol, ok);
        n_checks++; if (ct !== CT1) begin n_fail++; $display("FAIL busy_start_ct1 got %h want %h", ct, CT1); end
        iv = IV_X; start = 1'b1;
        send_block(PT2, 1'b1, ct, ol, ok);
        start = 1'b0;
        n_checks++; if (ct !== CT2) begin n_fail++; $display("FAIL busy_start_ct2 got %h want %h", ct, CT2); end
        tick();
    endtask

    task automatic test_max_blocks();
        logic [128:1] pts [4] = '{PT1, PT2, PT3, PT4};
        logic [128:1] cts [4] = '{CT1, CT2, CT3, CT4};
        logic [128:1] ct; logic ol, ok;
        sel = 1'b1;
        do_start(KEY, IV);
        for (int b = 0; b < 4; b++) begin
            send_block(pts[b], 1'b0, ct, ol, ok);
            n_checks++; if (ok !== 1'b1 || ct !== cts[b]) begin n_fail++; $display("FAIL max_ct%0d got %h want %h (ok=%b)", b + 1, ct, cts[b], ok); end
            n_checks++; if (ol !== (b == 3)) begin n_fail++; $display("FAIL max_last%0d got %b want %b", b + 1, ol, (b == 3)); end
        end
        n_checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL max_idle done=%b busy=%b want 1/0", done_o, busy_o); end
        n_checks++; if (cnt_o !== 17'd4) begin n_fail++; $display("FAIL max_blk_count got %0d want 4", cnt_o); end
        tick();
        sel = 1'b0;
    endtask

    task automatic test_round_trip();
        logic [128:1] cts [4] = '{CT1, CT2, CT3, CT4};
        logic [128:1] pts [4] = '{PT1, PT2, PT3, PT4};
        logic [128:1] pt; logic ol, ok;
        do_start(KEY, IV);
        for (int b = 0; b < 4; b++) begin
            send_block(cts[b], (b == 3), pt, ol, ok);
            n_checks++; if (ok !== 1'b1 || pt !== pts[b]) begin n_fail++; $display("FAIL round_trip_pt%0d got %h want %h (ok=%b)", b + 1, pt, pts[b], ok); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sp800_block1();
        test_four_block();
        test_backpressure();
        test_rst_mid();
        test_start_busy();
        test_max_blocks();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end
endmodule
